// File: rtl/clod_pim_match_engine_if.sv
// rtl/clod_pim_match_engine_if.sv - request/result bundle for the row match engine
// The engine sits on the slave modport; the producer/consumer side uses master.
interface clod_pim_match_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 256
);
  localparam int CW = $clog2(ARRAY_SIZE + 1);
  localparam int IW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_a;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_b;
  logic [ARRAY_SIZE-1:0]            elem_mask;
  logic [1:0]                       mode;
  logic                             out_valid;
  logic                             out_ready;
  logic [ARRAY_SIZE-1:0]            match_out;
  logic [CW-1:0]                    match_count;
  logic                             any_match;
  logic [IW-1:0]                    first_idx;

  modport master (
    output in_valid, row_a, row_b, elem_mask, mode, out_ready,
    input  in_ready, out_valid, match_out, match_count, any_match, first_idx
  );

  modport slave (
    input  in_valid, row_a, row_b, elem_mask, mode, out_ready,
    output in_ready, out_valid, match_out, match_count, any_match, first_idx
  );
endinterface

// File: rtl/clod_pim_match_engine.sv
// rtl/clod_pim_match_engine.sv - masked element-wise row compare, LANES elements per beat
// Captures both rows, scans NUM_BEATS beats, then holds the bitmap/count/first-index until taken.
module clod_pim_match_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 256,
  parameter int LANES      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  clod_pim_match_engine_if.slave bus
);
  localparam int NUM_BEATS = ARRAY_SIZE / LANES;
  localparam int CW = $clog2(ARRAY_SIZE + 1);
  localparam int IW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int RW = ARRAY_SIZE * DATA_WIDTH;

  if (ARRAY_SIZE % LANES != 0) begin : g_bad_lanes
    $error("ARRAY_SIZE must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [RW-1:0]         a_q, a_d, b_q, b_d;
  logic [ARRAY_SIZE-1:0] mask_q, mask_d, match_q, match_d;
  logic [1:0]            mode_q, mode_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  any_q, any_d;
  logic [IW-1:0]         first_q, first_d;

  logic [LANES-1:0]      beat_bits;
  logic [CW-1:0]         beat_cnt;
  logic                  beat_hit;
  logic [IW-1:0]         beat_first;

  always_comb begin : beat_eval
    logic [DATA_WIDTH-1:0] ea;
    logic [DATA_WIDTH-1:0] eb;
    logic                  r;
    int                    idx;
    beat_bits  = '0;
    beat_cnt   = '0;
    beat_hit   = 1'b0;
    beat_first = '0;
    ea         = '0;
    eb         = '0;
    r          = 1'b0;
    idx        = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat_q) * LANES + l;
      ea  = a_q[idx*DATA_WIDTH +: DATA_WIDTH];
      eb  = b_q[idx*DATA_WIDTH +: DATA_WIDTH];
      case (mode_q)
        2'b00:   r = (ea == eb);
        2'b01:   r = (ea != eb);
        2'b10:   r = (ea < eb);
        default: r = (ea >= eb);
      endcase
      beat_bits[l] = r & mask_q[idx];
      beat_cnt     = beat_cnt + CW'(beat_bits[l]);
    end
    // Walk downward so the lowest set lane wins.
    for (int l = LANES - 1; l >= 0; l--) begin
      if (beat_bits[l]) begin
        beat_hit   = 1'b1;
        beat_first = IW'(int'(beat_q) * LANES + l);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    a_d           = a_q;
    b_d           = b_q;
    mask_d        = mask_q;
    mode_d        = mode_q;
    match_d       = match_q;
    count_d       = count_q;
    any_d         = any_q;
    first_d       = first_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.row_a;
          b_d     = bus.row_b;
          mask_d  = bus.elem_mask;
          mode_d  = bus.mode;
          match_d = '0;
          count_d = '0;
          any_d   = 1'b0;
          first_d = '0;
          beat_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        match_d[int'(beat_q)*LANES +: LANES] = beat_bits;
        count_d = count_q + beat_cnt;
        if (!any_q && beat_hit) begin
          any_d   = 1'b1;
          first_d = beat_first;
        end
        if (beat_q == BW'(NUM_BEATS - 1)) state_d = DONE;
        else                              beat_d  = beat_q + BW'(1);
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      match_q <= '0;
      count_q <= '0;
      any_q   <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      match_q <= match_d;
      count_q <= count_d;
      any_q   <= any_d;
      first_q <= first_d;
    end
  end

  assign bus.match_out   = match_q;
  assign bus.match_count = count_q;
  assign bus.any_match   = any_q;
  assign bus.first_idx   = first_q;
endmodule

// File: tb/tb_clod_pim_match_engine.sv
// tb/tb_clod_pim_match_engine.sv - directed checks of the match engine, 4-beat and 1-beat builds
// Inputs change on negedge; outputs are sampled 1 time unit after posedge.
module tb_clod_pim_match_engine;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  clod_pim_match_engine_if #(.DATA_WIDTH(8), .ARRAY_SIZE(16)) bus ();
  clod_pim_match_engine_if #(.DATA_WIDTH(8), .ARRAY_SIZE(16)) bus1 ();

  clod_pim_match_engine #(.DATA_WIDTH(8), .ARRAY_SIZE(16), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clod_pim_match_engine #(.DATA_WIDTH(8), .ARRAY_SIZE(16), .LANES(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [127:0] ident, rev, b5;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [127:0] a, input logic [127:0] b, input logic [15:0] m,
                     input logic [1:0] md, output int lat);
    @(negedge clk);
    bus.row_a = a; bus.row_b = b; bus.elem_mask = m; bus.mode = md; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Garble the inputs right after accept: the scan must use the captured copies.
    bus.in_valid = 1'b0; bus.row_a = b ^ 128'h5a; bus.row_b = a; bus.elem_mask = ~m; bus.mode = ~md;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic res(input string tag, input int lat, input logic [15:0] em, input int ec,
                     input int ef, input logic ea);
    chk({tag, "_lat"},   64'(lat), 64'd4);
    chk({tag, "_match"}, 64'(bus.match_out), 64'(em));
    chk({tag, "_count"}, 64'(bus.match_count), 64'(ec));
    chk({tag, "_first"}, 64'(bus.first_idx), 64'(ef));
    chk({tag, "_any"},   64'(bus.any_match), 64'(ea));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    int saw;
    for (int i = 0; i < 16; i++) begin
      ident[i*8 +: 8] = 8'(i);
      rev[i*8 +: 8]   = 8'(15 - i);
    end
    b5 = ident;
    b5[40 +: 8] = 8'h99;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.row_a = '0; bus.row_b = '0;
    bus.elem_mask = '0; bus.mode = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.row_a = '0; bus1.row_b = '0;
    bus1.elem_mask = '0; bus1.mode = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_match",     64'(bus.match_out), 64'd0);
    chk("rst_count",     64'(bus.match_count), 64'd0);
    chk("rst_any",       64'(bus.any_match), 64'd0);
    chk("rst_first",     64'(bus.first_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    req(ident, ident, 16'hffff, 2'b00, lat);
    res("eq_all", lat, 16'hffff, 16, 0, 1'b1);
    req(ident, rev, 16'hffff, 2'b10, lat);
    res("lt", lat, 16'h00ff, 8, 0, 1'b1);
    req(ident, rev, 16'hffff, 2'b11, lat);
    res("ge", lat, 16'hff00, 8, 8, 1'b1);
    req(ident, ident, 16'h0000, 2'b00, lat);
    res("mask0", lat, 16'h0000, 0, 0, 1'b0);
    req(ident, ident, 16'h8000, 2'b00, lat);
    res("mask15", lat, 16'h8000, 1, 15, 1'b1);

    // Backpressure: a second request waits while the first result is held.
    req(ident, ident, 16'hffff, 2'b00, lat);
    chk("bp_lat", 64'(lat), 64'd4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.row_a = ident; bus.row_b = rev; bus.elem_mask = 16'hffff; bus.mode = 2'b10;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",  64'(bus.in_ready), 64'd0);
      chk("bp_match",     64'(bus.match_out), 64'hffff);
      chk("bp_count",     64'(bus.match_count), 64'd16);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_idle_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_idle_hold",  64'(bus.match_out), 64'hffff);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res("bp_second", lat, 16'h00ff, 8, 0, 1'b1);

    // Reset while beat 2 is being scanned.
    @(negedge clk);
    bus.row_a = ident; bus.row_b = ident; bus.elem_mask = 16'hffff; bus.mode = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready",  64'(bus.in_ready), 64'd1);
    chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_match",     64'(bus.match_out), 64'd0);
    chk("mid_count",     64'(bus.match_count), 64'd0);
    chk("mid_any",       64'(bus.any_match), 64'd0);
    chk("mid_first",     64'(bus.first_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) saw++;
    end
    chk("mid_no_valid", 64'(saw), 64'd0);
    req(ident, rev, 16'hffff, 2'b11, lat);
    res("mid_after", lat, 16'hff00, 8, 8, 1'b1);

    // Single-beat build, NEQ with one differing element.
    @(negedge clk);
    bus1.row_a = ident; bus1.row_b = b5; bus1.elem_mask = 16'hffff; bus1.mode = 2'b01;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0; bus1.row_b = ident; bus1.mode = 2'b00;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("one_lat",   64'(lat), 64'd1);
    chk("one_match", 64'(bus1.match_out), 64'h0020);
    chk("one_count", 64'(bus1.match_count), 64'd1);
    chk("one_first", 64'(bus1.first_idx), 64'd5);
    chk("one_any",   64'(bus1.any_match), 64'd1);
    @(negedge clk);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    chk("one_idle", 64'(bus1.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
